// File: rtl/fib_step_engine_if.sv
// Handshake bundle for fib_step_engine: job request, stage fault flag and result.
// err_cnt is carried only when FIB_ERR_CNT_EN is defined.
interface fib_step_engine_if #(
    parameter int W       = 16,
    parameter int STEPS_W = 5
);
    logic               start_valid;
    logic               start_ready;
    logic [W-1:0]       a_in;
    logic [W-1:0]       b_in;
    logic [STEPS_W-1:0] steps_in;
    logic               err_in;
    logic [W-1:0]       s_out;
    logic [W-1:0]       b_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               ovf;
`ifdef FIB_ERR_CNT_EN
    logic [STEPS_W-1:0] err_cnt;
`endif

    modport master (
        output start_valid, a_in, b_in, steps_in, err_in, out_ready,
        input  start_ready, s_out, b_out, out_valid, busy, ovf
`ifdef FIB_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  start_valid, a_in, b_in, steps_in, err_in, out_ready,
        output start_ready, s_out, b_out, out_valid, busy, ovf
`ifdef FIB_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/fib_step_engine.sv
// Steps a Fibonacci pair (hi, lo) through N stages, one per clock, with per-stage bypass
// and saturating arithmetic. Define FIB_ERR_CNT_EN to compile in the bypassed-stage counter.
module fib_step_engine #(
    parameter int W       = 16,
    parameter int STEPS_W = 5
) (
    input logic                clk,
    input logic                rst,
    fib_step_engine_if.slave   io
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;
    logic [STEPS_W-1:0] cnt;
    logic               ovf;
    logic               start_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [W:0]         sum;

    function automatic logic [W:0] wide_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // A carry out of the W-bit range clamps to all ones.
    function automatic logic [W-1:0] saturate(input logic [W:0] s);
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    assign sum = wide_sum(hi, lo);

`ifdef FIB_ERR_CNT_EN
    logic [STEPS_W-1:0] err_cnt;
    assign io.err_cnt = err_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hi            <= '0;
            lo            <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            start_ready_r <= 1'b1;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
`ifdef FIB_ERR_CNT_EN
            err_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (io.start_valid) begin
                        hi            <= io.b_in;
                        lo            <= io.a_in;
                        cnt           <= io.steps_in;
                        ovf           <= 1'b0;
                        start_ready_r <= 1'b0;
`ifdef FIB_ERR_CNT_EN
                        err_cnt       <= '0;
`endif
                        if (io.steps_in != '0) begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A bypassed stage holds the pair but still consumes a step.
                    if (!io.err_in) begin
                        hi <= saturate(sum);
                        lo <= hi;
                        if (sum[W]) ovf <= 1'b1;
                    end
`ifdef FIB_ERR_CNT_EN
                    else if (err_cnt != {STEPS_W{1'b1}}) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
`endif
                    cnt <= cnt - 1'b1;
                    if (cnt == STEPS_W'(1)) begin
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state         <= IDLE;
                        out_valid_r   <= 1'b0;
                        start_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    out_valid_r   <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign io.start_ready = start_ready_r;
    assign io.out_valid   = out_valid_r;
    assign io.busy        = busy_r;
    assign io.ovf         = ovf;
    assign io.s_out       = hi;
    assign io.b_out       = lo;
endmodule

// File: tb/tb_fib_step_engine.sv
// Directed bench for fib_step_engine: a 16-bit and an 8-bit instance run the same jobs in lockstep.
module tb_fib_step_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fib_step_engine_if #(.W(16), .STEPS_W(5)) if16 ();
    fib_step_engine_if #(.W(8),  .STEPS_W(5)) if8 ();

    assign if8.start_valid = if16.start_valid;
    assign if8.a_in        = if16.a_in[7:0];
    assign if8.b_in        = if16.b_in[7:0];
    assign if8.steps_in    = if16.steps_in;
    assign if8.err_in      = if16.err_in;
    assign if8.out_ready   = if16.out_ready;

    fib_step_engine #(.W(16), .STEPS_W(5)) dut16 (.clk(clk), .rst(rst), .io(if16));
    fib_step_engine #(.W(8),  .STEPS_W(5)) dut8  (.clk(clk), .rst(rst), .io(if8));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  n;
        logic [31:0] mask;
        logic [15:0] s16;
        logic [15:0] b16;
        logic        ovf16;
        logic [7:0]  s8;
        logic [7:0]  b8;
        logic        ovf8;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int idx, input vec_t v);
        int   edges;
        logic busy_seen;
        @(negedge clk);
        check($sformatf("v%0d start_ready", idx), 32'(if16.start_ready), 32'd1);
        if16.start_valid = 1'b1;
        if16.a_in        = v.a;
        if16.b_in        = v.b;
        if16.steps_in    = v.n;
        if16.err_in      = 1'b0;
        @(posedge clk);
        #1;
        if16.start_valid = 1'b0;
        edges     = 0;
        busy_seen = if16.busy;
        while (!if16.out_valid && edges < 40) begin
            if16.err_in = v.mask[edges[4:0]];
            @(posedge clk);
            #1;
            edges++;
            busy_seen = busy_seen | if16.busy;
        end
        if16.err_in = 1'b0;
        check($sformatf("v%0d latency_edges", idx), 32'(edges), 32'(v.n));
        check($sformatf("v%0d busy_seen", idx), 32'(busy_seen), 32'(v.n != 5'd0));
        check($sformatf("v%0d s16", idx), 32'(if16.s_out), 32'(v.s16));
        check($sformatf("v%0d b16", idx), 32'(if16.b_out), 32'(v.b16));
        check($sformatf("v%0d ovf16", idx), 32'(if16.ovf), 32'(v.ovf16));
        check($sformatf("v%0d s8", idx), 32'(if8.s_out), 32'(v.s8));
        check($sformatf("v%0d b8", idx), 32'(if8.b_out), 32'(v.b8));
        check($sformatf("v%0d ovf8", idx), 32'(if8.ovf), 32'(v.ovf8));
`ifdef FIB_ERR_CNT_EN
        check($sformatf("v%0d err_cnt", idx), 32'(if16.err_cnt), 32'(v.ecnt));
`endif
        @(posedge clk);
        #1;
        check($sformatf("v%0d back_to_idle", idx), 32'(if16.out_valid), 32'd0);
        check($sformatf("v%0d held_s16", idx), 32'(if16.s_out), 32'(v.s16));
    endtask

    initial begin
        //        a      b      n   mask       s16    b16   o16  s8   b8   o8  ecnt
        vecs[0] = '{16'd1,     16'd2,     5'd4,  32'h0, 16'd13,    16'd8,     1'b0, 8'd13,  8'd8,   1'b0, 5'd0};
        vecs[1] = '{16'd1,     16'd2,     5'd4,  32'h2, 16'd8,     16'd5,     1'b0, 8'd8,   8'd5,   1'b0, 5'd1};
        vecs[2] = '{16'd5,     16'd8,     5'd0,  32'h0, 16'd8,     16'd5,     1'b0, 8'd8,   8'd5,   1'b0, 5'd0};
        vecs[3] = '{16'd89,    16'd144,   5'd2,  32'h0, 16'd377,   16'd233,   1'b0, 8'd255, 8'd233, 1'b1, 5'd0};
        vecs[4] = '{16'd1,     16'd1,     5'd1,  32'h0, 16'd2,     16'd1,     1'b0, 8'd2,   8'd1,   1'b0, 5'd0};
        vecs[5] = '{16'd200,   16'd100,   5'd3,  32'h0, 16'd700,   16'd400,   1'b0, 8'd255, 8'd255, 1'b1, 5'd0};
        vecs[6] = '{16'd3,     16'd4,     5'd3,  32'h7, 16'd4,     16'd3,     1'b0, 8'd4,   8'd3,   1'b0, 5'd3};
        vecs[7] = '{16'd0,     16'd1,     5'd20, 32'h0, 16'd10946, 16'd6765,  1'b0, 8'd255, 8'd255, 1'b1, 5'd0};
        vecs[8] = '{16'd28657, 16'd46368, 5'd1,  32'h0, 16'd65535, 16'd46368, 1'b1, 8'd255, 8'd32,  1'b1, 5'd0};

        if16.start_valid = 1'b0;
        if16.a_in        = '0;
        if16.b_in        = '0;
        if16.steps_in    = '0;
        if16.err_in      = 1'b0;
        if16.out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst start_ready", 32'(if16.start_ready), 32'd1);
        check("rst out_valid", 32'(if16.out_valid), 32'd0);
        check("rst busy", 32'(if16.busy), 32'd0);
        check("rst ovf", 32'(if16.ovf), 32'd0);
        check("rst s_out", 32'(if16.s_out), 32'd0);
        check("rst b_out", 32'(if16.b_out), 32'd0);
`ifdef FIB_ERR_CNT_EN
        check("rst err_cnt", 32'(if16.err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_job(i, vecs[i]);

        // Backpressure: result held in DONE while a new start is pending.
        @(negedge clk);
        if16.out_ready   = 1'b0;
        if16.start_valid = 1'b1;
        if16.a_in        = 16'd1;
        if16.b_in        = 16'd2;
        if16.steps_in    = 5'd1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("bp valid", 32'(if16.out_valid), 32'd1);
        check("bp s_out", 32'(if16.s_out), 32'd3);
        check("bp b_out", 32'(if16.b_out), 32'd2);
        if16.a_in     = 16'd5;
        if16.b_in     = 16'd8;
        if16.steps_in = 5'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d valid", k), 32'(if16.out_valid), 32'd1);
            check($sformatf("bp%0d s_out", k), 32'(if16.s_out), 32'd3);
            check($sformatf("bp%0d b_out", k), 32'(if16.b_out), 32'd2);
            check($sformatf("bp%0d start_ready", k), 32'(if16.start_ready), 32'd0);
        end
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp idle valid", 32'(if16.out_valid), 32'd0);
        check("bp idle start_ready", 32'(if16.start_ready), 32'd1);
        check("bp idle s_out", 32'(if16.s_out), 32'd3);
        @(posedge clk);
        #1;
        if16.start_valid = 1'b0;
        check("bp next valid", 32'(if16.out_valid), 32'd1);
        check("bp next s_out", 32'(if16.s_out), 32'd8);
        check("bp next b_out", 32'(if16.b_out), 32'd5);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-RUN, between clock edges.
        @(negedge clk);
        if16.start_valid = 1'b1;
        if16.a_in        = 16'd1;
        if16.b_in        = 16'd2;
        if16.steps_in    = 5'd10;
        @(posedge clk);
        #1;
        if16.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst start_ready", 32'(if16.start_ready), 32'd1);
        check("arst out_valid", 32'(if16.out_valid), 32'd0);
        check("arst busy", 32'(if16.busy), 32'd0);
        check("arst ovf", 32'(if16.ovf), 32'd0);
        check("arst s_out", 32'(if16.s_out), 32'd0);
        check("arst b_out", 32'(if16.b_out), 32'd0);
`ifdef FIB_ERR_CNT_EN
        check("arst err_cnt", 32'(if16.err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("arst hold valid", 32'(if16.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(9, '{16'd1, 16'd2, 5'd1, 32'h0, 16'd3, 16'd2, 1'b0, 8'd3, 8'd2, 1'b0, 5'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
